// File: rtl/data_cache_wb.sv
// data_cache_wb: N-way set-associative, write-back, write-allocate data cache
// for the Memory stage of the RV32I pipeline.
//
// Pipeline side : req, WE, funct3, A, WD -> RD (combinational on hit), stall.
// Memory side   : one word per beat; mem_req/mem_we/mem_addr/mem_wdata out,
//                 mem_rdata/mem_ack in. mem_ack is only looked at in WB/FILL.
// Optional      : define DCACHE_PERF_EN to add saturating hit_count/miss_count.
//
// A miss walks IDLE -> (WB) -> FILL -> RESP -> IDLE. RESP replays the held
// access as a hit, so the pipeline sees stall drop with RD valid.
module data_cache_wb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  WE,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] WD,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
`ifdef DCACHE_PERF_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int SET_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - 2 - OFF_W - SET_W;
    localparam int WI_W  = (LINE_WORDS > 1) ? OFF_W : 1;
    localparam int WP_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WB   = 2'd1;
    localparam logic [1:0] FILL = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [WAYS-1:0][SETS-1:0] validArr, dirtyArr;
    logic [TAG_W-1:0]          tagArr  [WAYS][SETS];
    logic [DATA_WIDTH-1:0]     dataArr [WAYS][SETS][LINE_WORDS];
    logic [WP_W-1:0]           rrPtr   [SETS];

    logic [1:0]      state;
    logic [WI_W-1:0] beat;
    logic [WP_W-1:0] vicWay;

    // Address decode; bits of A above ADDR_WIDTH are don't-care.
    logic [ADDR_WIDTH-1:0] addr;
    logic [TAG_W-1:0]      tagIn;
    logic [SET_W-1:0]      setIdx;
    logic [WI_W-1:0]       wordIdx;
    logic                  unusedHiBits;
    assign addr         = A[ADDR_WIDTH-1:0];
    assign unusedHiBits = ^A[DATA_WIDTH-1:ADDR_WIDTH];
    assign tagIn        = TAG_W'(addr >> (2 + OFF_W + SET_W));
    assign setIdx       = SET_W'(addr >> (2 + OFF_W));
    assign wordIdx      = (LINE_WORDS > 1) ? WI_W'(addr >> 2) : '0;

    logic            hit;
    logic [WP_W-1:0] hitWay, vicSel;
    always_comb begin
        hit    = 1'b0;
        hitWay = '0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (validArr[w][setIdx] && tagArr[w][setIdx] == tagIn) begin
                hit    = 1'b1;
                hitWay = WP_W'(w);
            end
    end

    // Lowest invalid way wins; the round-robin pointer only matters when the set is full.
    always_comb begin
        vicSel = rrPtr[setIdx];
        for (int w = WAYS - 1; w >= 0; w--)
            if (!validArr[w][setIdx]) vicSel = WP_W'(w);
    end

    logic service, lastBeat;
    assign service  = req && hit && (state == IDLE || state == RESP);
    assign lastBeat = (beat == WI_W'(LINE_WORDS - 1));

    // Load path
    logic [DATA_WIDTH-1:0] hitWord;
    logic [7:0]            bSel;
    logic [15:0]           hSel;
    assign hitWord = dataArr[hitWay][setIdx][wordIdx];
    assign bSel    = hitWord[{A[1:0], 3'b000} +: 8];
    assign hSel    = hitWord[{A[1], 4'b0000} +: 16];
    always_comb begin
        RD = '0;
        if (service)
            case (funct3)
                3'b000:  RD = {{24{bSel[7]}}, bSel};
                3'b001:  RD = {{16{hSel[15]}}, hSel};
                3'b100:  RD = {24'b0, bSel};
                3'b101:  RD = {16'b0, hSel};
                default: RD = hitWord;
            endcase
    end

    // Store path: replicate the store data across lanes, then mask.
    logic [3:0]            wMask;
    logic [DATA_WIDTH-1:0] sData;
    always_comb begin
        case (funct3[1:0])
            2'b00:   begin wMask = 4'b0001 << A[1:0];            sData = {4{WD[7:0]}};  end
            2'b01:   begin wMask = A[1] ? 4'b1100 : 4'b0011;     sData = {2{WD[15:0]}}; end
            default: begin wMask = 4'b1111;                      sData = WD;            end
        endcase
    end

    // Memory side
    logic [TAG_W-1:0] beatTag;
    assign beatTag   = (state == WB) ? tagArr[vicWay][setIdx] : tagIn;
    assign stall     = (state == IDLE && req && !hit) || state == WB || state == FILL;
    assign mem_req   = (state == WB) || (state == FILL);
    assign mem_we    = (state == WB);
    assign mem_addr  = mem_req ? ((ADDR_WIDTH'(beatTag) << (2 + OFF_W + SET_W)) |
                                  (ADDR_WIDTH'(setIdx) << (2 + OFF_W)) |
                                  (ADDR_WIDTH'(beat) << 2)) : '0;
    assign mem_wdata = (state == WB) ? dataArr[vicWay][setIdx][beat] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat     <= '0;
            vicWay   <= '0;
            validArr <= '0;
            dirtyArr <= '0;
            for (int s = 0; s < SETS; s++) rrPtr[s] <= '0;
        end else begin
            case (state)
                IDLE: if (req && !hit) begin
                    vicWay <= vicSel;
                    beat   <= '0;
                    state  <= (validArr[vicSel][setIdx] && dirtyArr[vicSel][setIdx]) ? WB : FILL;
                end
                WB: if (mem_ack) begin
                    beat <= lastBeat ? '0 : beat + 1'b1;
                    if (lastBeat) state <= FILL;
                end
                FILL: if (mem_ack) begin
                    beat <= lastBeat ? '0 : beat + 1'b1;
                    if (lastBeat) begin
                        validArr[vicWay][setIdx] <= 1'b1;
                        dirtyArr[vicWay][setIdx] <= 1'b0;
                        rrPtr[setIdx] <= (WAYS > 1) ? rrPtr[setIdx] + 1'b1 : '0;
                        state <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
            if (service && WE) dirtyArr[hitWay][setIdx] <= 1'b1;
        end
    end

    // Tag and line RAM carry no reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == FILL && mem_ack) begin
                dataArr[vicWay][setIdx][beat] <= mem_rdata;
                if (lastBeat) tagArr[vicWay][setIdx] <= tagIn;
            end
            if (service && WE)
                for (int l = 0; l < 4; l++)
                    if (wMask[l]) dataArr[hitWay][setIdx][wordIdx][8*l +: 8] <= sData[8*l +: 8];
        end
    end

`ifdef DCACHE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE && req) begin
            if (hit && hit_count != 32'hFFFF_FFFF)        hit_count  <= hit_count + 1'b1;
            if (!hit && miss_count != 32'hFFFF_FFFF)      miss_count <= miss_count + 1'b1;
        end
    end
`endif
endmodule

// File: doc/data_cache_wb.md
Name: data_cache_wb

Overview:
- Parametrised successor to the current 2-way write-through data cache in the Memory stage of the 5-stage RV32I pipeline.
- N-way set-associative, write-back, write-allocate cache with multi-word lines.
- Faces the pipeline through the existing load/store interface (WE/funct3/A/WD/RD) plus a stall output to the hazard unit.
- Faces the backing memory through a beat-per-word request/acknowledge handshake.

Parameters:
DATA_WIDTH, 32, word width (fixed 32 for RV32; byte lanes = DATA_WIDTH/8)
ADDR_WIDTH, 17, byte-address bits used; higher bits of A ignored
WAYS, 2, associativity; power of two, 1..8
SETS, 64, sets per way; power of two
LINE_WORDS, 4, words per line; power of two, 1..16

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  1  Memory stage holds a load or store this cycle
WE  in  1  1 = store, 0 = load (valid with req)
funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010
A  in  DATA_WIDTH  byte address
WD  in  DATA_WIDTH  store data, right-aligned
RD  out  DATA_WIDTH  load data, extended per funct3
stall  out  1  to hazard unit; freezes F/D/E/M while high
mem_req  out  1  beat request to backing memory
mem_we  out  1  1 = write beat, 0 = read beat
mem_addr  out  ADDR_WIDTH  word-aligned beat address
mem_wdata  out  DATA_WIDTH  write-beat data
mem_rdata  in  DATA_WIDTH  read-beat data, valid with mem_ack
mem_ack  in  1  beat complete; ignored while mem_req=0

Behaviour:
- Address split: [1:0] byte offset; next log2(LINE_WORDS) bits word index; next log2(SETS) bits set index; remaining bits up to ADDR_WIDTH-1 tag.
- Halfword accesses drop A[0]; word accesses drop A[1:0]. No misalignment trap.
- Per line: valid, dirty, tag, LINE_WORDS words. Per set: round-robin victim pointer of log2(WAYS) bits.
- Victim choice: the first invalid way (lowest index); otherwise the way under the pointer. The pointer advances by 1 mod WAYS on each refill of that set.
- Hit (IDLE, req=1, tag match on a valid way):
  - stall=0.
  - Load: RD is combinational, same cycle.
  - Store: bytes merge into the hit word at the clock edge and dirty is set. No memory traffic.
- Miss (IDLE, req=1, no match): stall=1 combinationally in the same cycle. The FSM leaves IDLE at the next edge.
- FSM states:
  - IDLE: exits to WB if the victim is valid and dirty, else to FILL.
  - WB: LINE_WORDS write beats, word 0 first. mem_addr = {victim tag, set, beat, 2'b00}. The beat counter advances on mem_ack. After the last ack, go to FILL.
  - FILL: LINE_WORDS read beats at the requested tag/set. Each ack writes mem_rdata into the victim word. After the last ack, set valid, clear dirty, write the tag, and go to RESP.
  - RESP: one cycle. The access is now a hit and is serviced as in IDLE, so a store sets dirty. stall=0 in this cycle. Return to IDLE.
- Memory handshake during WB/FILL: mem_req stays 1 across back-to-back beats. mem_addr and mem_wdata stay stable until ack. Minimum 1 cycle per beat.
- Miss latency with zero-wait memory: clean victim = LINE_WORDS+1 stalled cycles; dirty victim = 2*LINE_WORDS+1.
- Pipeline holds req/WE/funct3/A/WD stable while stall=1. req=0 in IDLE: no state change, stall=0.
- Loads: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Stores: SB writes lane A[1:0]; SH writes lanes {A[1],0} and {A[1],1}; SW writes all lanes.
- Reset:
  - All valid, dirty and victim pointers cleared. FSM to IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, stall=0, RD=0 while req=0.
  - Reset mid-WB/FILL aborts the transfer at once; dirty data is lost.
  - Line data RAM is not cleared.
- mem_ack arriving in IDLE or RESP is ignored.

Optional Feature:
- Macro: DCACHE_PERF_EN.
- When defined, adds two outputs: hit_count out 32 and miss_count out 32, both reset to 0.
  - hit_count increments on each IDLE hit.
  - miss_count increments on each IDLE-to-WB/FILL transition.
  - Both saturate at 32'hFFFF_FFFF. The RESP service does not count as a hit.
- When undefined, the ports and counters are absent and all other behaviour is identical.

Test Plan:
- Cold LW A=0x100, zero-wait memory returning word-address data:
  - stall high 5 cycles, 4 read beats at 0x100, 0x104, 0x108, 0x10C.
  - RD = beat-0 data in RESP; a following LW 0x104 hits with stall=0.
- SB WD=0x000000F0 to 0x101 after the line fills, then LB 0x101 -> RD=0xFFFFFFF0; LBU 0x101 -> RD=0x000000F0; no memory traffic.
- WAYS=2: dirty line at 0x100, then loads to 0x100+SETS*16 and 0x100+2*SETS*16:
  - third access emits 4 write beats of the dirty 0x100 line (byte F0 merged) before 4 read beats.
  - stall high 9 cycles.
- Memory ack delayed 3 cycles per beat -> mem_addr/mem_wdata stable while mem_req=1; beat counter advances only on ack.
- rst pulsed during the 2nd FILL beat -> next cycle mem_req=0, stall=0; a repeat LW 0x100 misses again.
- DCACHE_PERF_EN: 1 miss plus 3 hits -> miss_count=1, hit_count=3.
